fir_output_stage: RTL

//  Output stage downstream of the last filter_block_step tap in the FIR chain.
//  - Discards chain-fill samples.
//  - Rounds and scales the wide accumulator y, then saturates it to the output width.
//  - Buffers results in a small FIFO with a valid/ready output interface.
//  - Keeps sticky saturation and drop flags for host/status readout.

---
 rtl/fir_pkg.sv | 63 ++++++
 rtl/fir_output_stage_fifo.sv | 65 ++++++
 rtl/fir_output_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the round/saturate helper for the FIR output stage.
package fir_pkg;

    // Widest signal the round/saturate helper works on.
    localparam int FIR_MAXW = 64;

    // Default configuration of the output stage.
    localparam int FIR_WIDTH_Y    = 32;
    localparam int FIR_WIDTH_O    = 16;
    localparam int FIR_SHIFT      = 15;
    localparam int FIR_NTAPS      = 8;
    localparam int FIR_FIFO_DEPTH = 4;

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    function automatic logic [FIR_MAXW-1:0] fir_round_const(input int shift);
        if (shift > 0) begin
            return 64'd1 << (shift - 1);
        end else begin
            return 64'd0;
        end
    endfunction

    // Largest value representable in a signed output of width w.
    function automatic logic signed [FIR_MAXW-1:0] fir_out_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed output of width w.
    function automatic logic signed [FIR_MAXW-1:0] fir_out_min(input int w);
        return -fir_out_max(w) - 64'sd1;
    endfunction

    localparam logic [FIR_MAXW-1:0]        FIR_ROUND_C = fir_round_const(FIR_SHIFT);
    localparam logic signed [FIR_MAXW-1:0] FIR_OUT_MAX = fir_out_max(FIR_WIDTH_O);
    localparam logic signed [FIR_MAXW-1:0] FIR_OUT_MIN = fir_out_min(FIR_WIDTH_O);

    // Scale an already-rounded, sign-extended value and clamp it to width_o bits.
    // The caller truncates the result to width_o; sat reports whether a clamp hit.
    function automatic logic signed [FIR_MAXW-1:0] fir_round_sat(
        input  logic signed [FIR_MAXW-1:0] r,
        input  int                         shift,
        input  int                         width_o,
        output logic                       sat
    );
        logic signed [FIR_MAXW-1:0] q;
        logic signed [FIR_MAXW-1:0] hi;
        logic signed [FIR_MAXW-1:0] lo;
        q  = r >>> shift;
        hi = fir_out_max(width_o);
        lo = fir_out_min(width_o);
        if (q > hi) begin
            sat = 1'b1;
            return hi;
        end else if (q < lo) begin
            sat = 1'b1;
            return lo;
        end else begin
            sat = 1'b0;
            return q;
        end
    endfunction

endpackage

// File: rtl/fir_output_stage_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// Pointers carry one extra wrap bit so full and empty come from a plain compare.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      wr_d;
    logic [AW:0]      rd_q;
    logic [AW:0]      rd_d;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer compare, push/pop qualification and the fall-through read port.
    always_comb begin
        empty_s   = (wr_q == rd_q);
        full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop_s  = pop_i & ~empty_s;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push_s = push_i & (~full_s | do_pop_s);
        wr_d      = do_push_s ? (wr_q + {{AW{1'b0}}, 1'b1}) : wr_q;
        rd_d      = do_pop_s  ? (rd_q + {{AW{1'b0}}, 1'b1}) : rd_q;
        if (empty_s) begin
            dout_o = {WIDTH{1'b0}};
        end else begin
            dout_o = mem_q[rd_q[AW-1:0]];
        end
        valid_o = ~empty_s;
        full_o  = full_s;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: discards chain-fill samples, rounds/scales/saturates the
// last tap's accumulator, buffers results and keeps sticky status flags.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int WIDTH_Y    = FIR_WIDTH_Y,
    parameter int WIDTH_O    = FIR_WIDTH_O,
    parameter int SHIFT      = FIR_SHIFT,
    parameter int NTAPS      = FIR_NTAPS,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [WIDTH_Y-1:0] y_in,
    input  logic               clr_flags,
    output logic [WIDTH_O-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               fifo_full,
    output logic               sat_sticky,
    output logic               drop_sticky
);

    localparam int                  CNT_W      = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CNT_W-1:0]    FILL_LAST  = CNT_W'(NTAPS - 1);
    localparam logic [FIR_MAXW-1:0] ROUND_C_W  = fir_round_const(SHIFT);
    localparam logic [WIDTH_Y:0]    ROUND_C    = ROUND_C_W[WIDTH_Y:0];

    logic [CNT_W-1:0]           fill_q;
    logic [CNT_W-1:0]           fill_d;
    logic                       primed_s;
    logic                       accept_s;
    logic signed [WIDTH_Y:0]    r1_q;
    logic signed [WIDTH_Y:0]    r1_d;
    logic                       v1_q;
    logic [WIDTH_O-1:0]         r2_q;
    logic [WIDTH_O-1:0]         r2_d;
    logic                       v2_q;
    logic signed [FIR_MAXW-1:0] r1_ext_s;
    logic                       sat_s;
    logic                       pop_s;
    logic                       drop_ev_s;
    logic                       sat_q;
    logic                       drop_q;

    // Priming, S1 rounding add and S2 scale/saturate next-state logic.
    always_comb begin
        primed_s = (fill_q == FILL_LAST);
        accept_s = ena & primed_s;
        if (ena && !primed_s) begin
            fill_d = fill_q + CNT_W'(1);
        end else begin
            fill_d = fill_q;
        end
        // One guard bit above the input keeps the rounding add from wrapping.
        r1_d     = {y_in[WIDTH_Y-1], y_in} + ROUND_C;
        r1_ext_s = {{(FIR_MAXW-WIDTH_Y-1){r1_q[WIDTH_Y]}}, r1_q};
        r2_d     = WIDTH_O'(fir_round_sat(r1_ext_s, SHIFT, WIDTH_O, sat_s));
        pop_s     = out_valid & out_ready;
        drop_ev_s = v2_q & fifo_full & ~pop_s;
    end

    // Fill counter, two pipeline stages and sticky flags (set beats clear).
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q <= {CNT_W{1'b0}};
            r1_q   <= {(WIDTH_Y+1){1'b0}};
            v1_q   <= 1'b0;
            r2_q   <= {WIDTH_O{1'b0}};
            v2_q   <= 1'b0;
            sat_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            v1_q   <= accept_s;
            if (accept_s) begin
                r1_q <= r1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                r2_q <= r2_d;
            end
            sat_q  <= (v1_q & sat_s) | (sat_q & ~clr_flags);
            drop_q <= drop_ev_s | (drop_q & ~clr_flags);
        end
    end

    assign sat_sticky  = sat_q;
    assign drop_sticky = drop_q;

    fir_sync_fifo #(
        .WIDTH (WIDTH_O),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (v2_q),
        .din_i   (r2_q),
        .pop_i   (out_ready),
        .dout_o  (out_data),
        .valid_o (out_valid),
        .full_o  (fifo_full)
    );

endmodule
